spi_exe_arbiter: RTL and testbench

- Arbitrates access to the shared SPI execution unit among N_REQ requesters.
- Selects one requester by fixed priority (highest index wins) or by rotating priority.
- Issues a one-cycle start pulse to the execution unit, holds the grant until the unit signals done or a timeout expires, then acknowledges the winner.
- Sits between the per-channel command sources and the SPI execution unit.

---
 rtl/spi_exe_arbiter.sv | 142 ++++++++++++++
 tb/tb_spi_exe_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_exe_arbiter.sv
// Arbiter granting the shared SPI execution unit to one of N_REQ requesters,
// by fixed or rotating priority, with start pulse, done/timeout wait and ack.
module spi_exe_arbiter #(
   parameter int N_REQ       = 8,
   parameter int TIMEOUT     = 1024,
   parameter int ROUND_ROBIN = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req,
   input  logic                     i_done,
   output logic                     o_start,
   output logic [N_REQ-1:0]         o_grant,
   output logic [$clog2(N_REQ)-1:0] o_grant_id,
   output logic [N_REQ-1:0]         o_ack,
   output logic                     o_timeout,
   output logic                     o_busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
   logic [IW-1:0]   last;
   logic [IW-1:0]   win_id;
   logic            timeout_hit;

   logic            start_nxt, busy_nxt, timeout_nxt;
   logic [N_REQ-1:0] grant_nxt, ack_nxt;
   logic [IW-1:0]   id_nxt;

   // Winner selection. Later loop iterations overwrite earlier ones, so each
   // loop runs from lowest to highest precedence.
   always_comb begin
      // NOTE: every variable written here gets a default first, otherwise an
      // unassigned path infers a latch.
      win_id = '0;
      if (ROUND_ROBIN != 0) begin
         for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[IW'((int'(last) + N_REQ - k) % N_REQ)])
               win_id = IW'((int'(last) + N_REQ - k) % N_REQ);
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (i_req[IW'(i)])
               win_id = IW'(i);
         end
      end
   end

   // Next-state logic and wait counter.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_hit  = 1'b0;
      case (state)
         S_IDLE:  if (|i_req) state_nxt = S_START;
         S_START: begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = '0;
         end
         S_WAIT: begin
            // i_done takes precedence over an expiring timeout.
            if (i_done) begin
               state_nxt = S_DONE;
            end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LIMIT)) begin
               state_nxt   = S_DONE;
               timeout_hit = 1'b1;
            end else if (wait_cnt != CNT_MAX) begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      start_nxt   = (state_nxt == S_START);
      busy_nxt    = (state_nxt != S_IDLE);
      grant_nxt   = o_grant;
      id_nxt      = o_grant_id;
      ack_nxt     = '0;
      timeout_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (|i_req) begin
               grant_nxt         = '0;
               grant_nxt[win_id] = 1'b1;
               id_nxt            = win_id;
            end
         end
         S_WAIT: begin
            if (state_nxt == S_DONE) begin
               ack_nxt     = o_grant;
               timeout_nxt = timeout_hit;
            end
         end
         S_DONE: begin
            grant_nxt = '0;
            id_nxt    = '0;
         end
         default: ;
      endcase
   end

   // NOTE: reset is sampled on the clock edge here, so a mid-transfer reset
   // clears the grant at the next edge without issuing an ack.
   always_ff @(posedge i_clk) begin
      // NOTE: state uses non-blocking assignments so every register updates
      // from the values present before the edge.
      if (!i_rst_n) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         last       <= '0;
         o_start    <= 1'b0;
         o_grant    <= '0;
         o_grant_id <= '0;
         o_ack      <= '0;
         o_timeout  <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         o_start    <= start_nxt;
         o_grant    <= grant_nxt;
         o_grant_id <= id_nxt;
         o_ack      <= ack_nxt;
         o_timeout  <= timeout_nxt;
         o_busy     <= busy_nxt;
         if (state == S_DONE)
            last <= o_grant_id;
      end
   end

endmodule

// File: tb/tb_spi_exe_arbiter.sv
// Directed bench for spi_exe_arbiter: a fixed-priority instance with a short
// timeout and a rotating-priority instance, checked cycle by cycle.
module tb_spi_exe_arbiter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: fixed priority, TIMEOUT=16
   logic       rst_n_a, done_a, start_a, timeout_a, busy_a;
   logic [7:0] req_a, grant_a, ack_a;
   logic [2:0] id_a;
   // Instance B: rotating priority, default timeout
   logic       rst_n_b, done_b, start_b, timeout_b, busy_b;
   logic [7:0] req_b, grant_b, ack_b;
   logic [2:0] id_b;

   int checks = 0;
   int errors = 0;
   int mon_errors = 0;
   int starts_b = 0;

   spi_exe_arbiter #(.N_REQ(8), .TIMEOUT(16), .ROUND_ROBIN(0)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n_a), .i_req(req_a), .i_done(done_a),
      .o_start(start_a), .o_grant(grant_a), .o_grant_id(id_a), .o_ack(ack_a),
      .o_timeout(timeout_a), .o_busy(busy_a)
   );

   spi_exe_arbiter #(.N_REQ(8), .TIMEOUT(1024), .ROUND_ROBIN(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n_b), .i_req(req_b), .i_done(done_b),
      .o_start(start_b), .o_grant(grant_b), .o_grant_id(id_b), .o_ack(ack_b),
      .o_timeout(timeout_b), .o_busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Structural invariants on both instances, sampled away from the active edge.
   always @(negedge clk) begin
      assert ($onehot0(grant_a) && ((ack_a & ~grant_a) == 8'h00) &&
              $onehot0(grant_b) && ((ack_b & ~grant_b) == 8'h00))
      else begin
         mon_errors++;
         $error("FAIL onehot_monitor: grant_a=%0h ack_a=%0h grant_b=%0h ack_b=%0h",
                grant_a, ack_a, grant_b, ack_b);
      end
      if (start_b === 1'b1) starts_b++;
   end

   int exp_ids [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

   initial begin
      rst_n_a = 1'b0; req_a = '0; done_a = 1'b0;
      rst_n_b = 1'b0; req_b = '0; done_b = 1'b0;
      tick();
      tick();
      check("rst_grant_a", grant_a, 8'h00);
      check("rst_id_a", id_a, 3'd0);
      check("rst_busy_a", busy_a, 1'b0);
      check("rst_start_a", start_a, 1'b0);
      check("rst_ack_b", ack_b, 8'h00);
      check("rst_busy_b", busy_b, 1'b0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      tick();
      check("idle_busy_a", busy_a, 1'b0);

      // 1: fixed priority, bits 5 and 2 requested
      req_a = 8'h24;
      tick();
      check("t1_grant5", grant_a, 8'h20);
      check("t1_id5", id_a, 3'd5);
      check("t1_start5", start_a, 1'b1);
      check("t1_busy5", busy_a, 1'b1);
      tick();
      check("t1_start_off", start_a, 1'b0);
      tick();
      tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("t1_ack5", ack_a, 8'h20);
      check("t1_nto5", timeout_a, 1'b0);
      check("t1_grant_done5", grant_a, 8'h20);
      req_a = 8'h04;
      tick();
      check("t1_ack_off", ack_a, 8'h00);
      check("t1_release", grant_a, 8'h00);
      check("t1_idle_busy", busy_a, 1'b0);
      tick();
      check("t1_grant2", grant_a, 8'h04);
      check("t1_id2", id_a, 3'd2);
      check("t1_start2", start_a, 1'b1);
      tick();
      tick();
      tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("t1_ack2", ack_a, 8'h04);
      req_a = 8'h00;
      tick();
      check("t1_end_busy", busy_a, 1'b0);
      check("t1_end_grant", grant_a, 8'h00);
      tick();
      check("t1_stay_idle", busy_a, 1'b0);

      // 2: rotating priority, all requests held
      req_b = 8'hFF;
      for (int n = 0; n < 9; n++) begin
         tick();
         check($sformatf("t2_id_%0d", n), id_b, exp_ids[n]);
         check($sformatf("t2_grant_%0d", n), grant_b, 32'h1 << exp_ids[n]);
         check($sformatf("t2_start_%0d", n), start_b, 1'b1);
         tick();
         check($sformatf("t2_start_off_%0d", n), start_b, 1'b0);
         done_b = 1'b1;
         tick();
         done_b = 1'b0;
         check($sformatf("t2_ack_%0d", n), ack_b, 32'h1 << exp_ids[n]);
         tick();
         check($sformatf("t2_idle_%0d", n), busy_b, 1'b0);
      end
      req_b = 8'h00;
      tick();
      check("t2_start_count", starts_b, 9);

      // 3: timeout with no i_done
      req_a = 8'h08;
      tick();
      check("t3_grant", grant_a, 8'h08);
      tick();
      repeat (15) tick();
      check("t3_no_ack_early", ack_a, 8'h00);
      check("t3_busy_wait", busy_a, 1'b1);
      tick();
      check("t3_ack", ack_a, 8'h08);
      check("t3_timeout", timeout_a, 1'b1);
      req_a = 8'h00;
      tick();
      check("t3_release", grant_a, 8'h00);
      check("t3_busy_off", busy_a, 1'b0);
      check("t3_timeout_off", timeout_a, 1'b0);

      // 4: i_done on the last counter value wins over timeout
      req_a = 8'h08;
      tick();
      tick();
      repeat (15) tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("t4_ack", ack_a, 8'h08);
      check("t4_no_timeout", timeout_a, 1'b0);
      req_a = 8'h00;
      tick();
      check("t4_idle", busy_a, 1'b0);

      // 5: reset during WAIT
      req_a = 8'h02;
      tick();
      check("t5_id", id_a, 3'd1);
      tick();
      tick();
      rst_n_a = 1'b0;
      tick();
      rst_n_a = 1'b1;
      check("t5_grant_rst", grant_a, 8'h00);
      check("t5_id_rst", id_a, 3'd0);
      check("t5_ack_rst", ack_a, 8'h00);
      check("t5_start_rst", start_a, 1'b0);
      check("t5_busy_rst", busy_a, 1'b0);
      check("t5_timeout_rst", timeout_a, 1'b0);
      tick();
      check("t5_regrant", grant_a, 8'h02);
      check("t5_regrant_id", id_a, 3'd1);
      check("t5_regrant_start", start_a, 1'b1);
      tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("t5_ack", ack_a, 8'h02);
      req_a = 8'h00;
      tick();
      check("t5_idle", busy_a, 1'b0);

      // 6: stray i_done pulses and a dropped request
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("t6_idle_stray_busy", busy_a, 1'b0);
      check("t6_idle_stray_ack", ack_a, 8'h00);
      req_a = 8'h10;
      tick();
      check("t6_start", start_a, 1'b1);
      check("t6_id", id_a, 3'd4);
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("t6_start_stray_ack", ack_a, 8'h00);
      check("t6_start_stray_busy", busy_a, 1'b1);
      req_a = 8'h00;
      tick();
      check("t6_wait_ack", ack_a, 8'h00);
      check("t6_wait_grant", grant_a, 8'h10);
      tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("t6_ack", ack_a, 8'h10);
      check("t6_grant_done", grant_a, 8'h10);
      tick();
      check("t6_idle", busy_a, 1'b0);
      check("t6_release", grant_a, 8'h00);

      check("onehot_monitor_errors", mon_errors, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
